// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: program counter plus IF/ID pipeline register.
// Optional stall/flush counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   id_pc_plus4,
  output logic              id_valid,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_pc;

  assign pc_plus4    = pc + PC_W'(4);
  assign redirect_pc = {branch_target[PC_W-1:2], 2'b00};
  assign imem_addr   = pc;

  // Redirect wins over stall so a branch resolved during a load-use bubble is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      id_inst     <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc          <= redirect_pc;
      id_inst     <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_plus4;
      id_inst     <= imem_data;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

  // A flushed slot holds an all-zero word, so hazard detection sees register 0.
  assign id_rs = id_inst[25:21];
  assign id_rt = id_inst[20:16];

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !branch_taken && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (branch_taken && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  if_stage #(.PC_W(32), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: plain pattern for directed tests, hashed pattern for random runs.
  logic        mode_plain = 1'b1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_word = '0;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (ovr_en)     return ovr_word;
    if (mode_plain) return a | 32'h2000_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_data = mem_at(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] p4;
    logic        valid;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_inst, m_ipc, m_p4;
  logic        m_valid;
  int          m_sc, m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_inst = '0; m_ipc = '0; m_p4 = '0; m_valid = 1'b0;
    m_sc = 0; m_fc = 0;
  endtask

  // Drive one cycle of stimulus, predict the state after the coming edge, then pass that edge.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    exp_t e;
    stall = st; branch_taken = br; branch_target = tgt;
    if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_inst = '0; m_ipc = '0; m_p4 = '0; m_valid = 1'b0;
      if (m_fc < 65535) m_fc++;
    end else if (st) begin
      if (m_sc < 65535) m_sc++;
    end else begin
      m_inst = mem_at(m_pc);
      m_ipc = m_pc;
      m_pc = m_pc + 32'd4;
      m_p4 = m_pc;
      m_valid = 1'b1;
    end
    e.pc = m_pc; e.inst = m_inst; e.ipc = m_ipc; e.p4 = m_p4; e.valid = m_valid;
`ifdef IF_PERF_CNT_EN
    e.sc = 16'(m_sc); e.fc = 16'(m_fc);
`else
    e.sc = 16'd0; e.fc = 16'd0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_imem_addr", imem_addr, e.pc);
        chk("sb_id_inst", id_inst, e.inst);
        chk("sb_id_pc", id_pc, e.ipc);
        chk("sb_id_pc_plus4", id_pc_plus4, e.p4);
        chk("sb_id_valid", {31'd0, id_valid}, {31'd0, e.valid});
        chk("sb_id_rs", {27'd0, id_rs}, (e.inst >> 21) & 32'd31);
        chk("sb_id_rt", {27'd0, id_rt}, (e.inst >> 16) & 32'd31);
        chk("sb_stall_cnt", {16'd0, stall_cnt}, {16'd0, e.sc});
        chk("sb_flush_cnt", {16'd0, flush_cnt}, {16'd0, e.fc});
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_rs_rt", {22'd0, id_rs, id_rt}, 32'd0);
    chk("rst_counters", {stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release and plain advance.
    repeat (3) step(1'b0, 1'b0, 32'd0);
    chk("adv_imem_addr", imem_addr, 32'd12);
    chk("adv_id_inst", id_inst, 32'h2000_0008);
    chk("adv_id_pc", id_pc, 32'd8);
    chk("adv_id_pc_plus4", id_pc_plus4, 32'd12);
    chk("adv_id_valid", {31'd0, id_valid}, 32'd1);

    // Stall holds everything, then advance resumes from the held PC.
    ovr_en = 1'b1; ovr_word = 32'h8C22_0004;
    step(1'b0, 1'b0, 32'd0);
    ovr_en = 1'b0;
    repeat (2) step(1'b1, 1'b0, 32'd0);
    chk("stall_id_inst", id_inst, 32'h8C22_0004);
    chk("stall_imem_addr", imem_addr, 32'd16);
    chk("stall_id_pc", id_pc, 32'd12);
    chk("stall_id_rs", {27'd0, id_rs}, 32'd1);
    chk("stall_id_rt", {27'd0, id_rt}, 32'd2);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt_two", {16'd0, stall_cnt}, 32'd2);
`endif
    step(1'b0, 1'b0, 32'd0);
    chk("resume_id_pc", id_pc, 32'd16);
    chk("resume_imem_addr", imem_addr, 32'd20);

    // Redirect takes priority over stall; target is word aligned.
    step(1'b1, 1'b1, 32'h0000_0103);
    chk("redir_imem_addr", imem_addr, 32'h100);
    chk("redir_id_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_id_inst", id_inst, 32'd0);
    chk("redir_rs_rt", {22'd0, id_rs, id_rt}, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("redir_id_pc", id_pc, 32'h100);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap_imem_addr", imem_addr, 32'd0);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc_plus4", id_pc_plus4, 32'd0);

    // Randomized mix of advance, stall and redirect.
    mode_plain = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, $urandom);
    end

    // Asynchronous reset between edges.
    step(1'b0, 1'b0, 32'd0);
    chk("pre_async_valid", {31'd0, id_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_imem_addr", imem_addr, RESET_PC);
    chk("async_id_valid", {31'd0, id_valid}, 32'd0);
    chk("async_id_inst", id_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    chk("post_rst_id_pc", id_pc, RESET_PC);
    chk("post_rst_imem_addr", imem_addr, RESET_PC + 32'd4);

`ifdef IF_PERF_CNT_EN
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 32'd0);
    chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif

    stall = 1'b0;
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with program counter and IF/ID pipeline register. Sits directly upstream of the load-use hazard detection unit: it presents the instruction memory address each cycle, captures the returned word into the IF/ID register, and exports the decoded source-register fields that hazard detection compares. It consumes the hazard unit's `stall` (freeze PC and IF/ID) and the execute stage's branch redirect (flush IF/ID).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `PC_W`, default 32: PC and address width.
- `INST_W`, default 32: instruction width; must be 32 for field extraction.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `stall`  in  1: from hazard detection; freeze PC and IF/ID.
- `branch_taken`  in  1: redirect request from execute.
- `branch_target`  in  PC_W: redirect address.
- `imem_addr`  out  PC_W: instruction memory address; equals the PC register.
- `imem_data`  in  INST_W: instruction word, combinational read of `imem_addr`.
- `id_inst`  out  INST_W: IF/ID instruction.
- `id_pc`  out  PC_W: address of `id_inst`.
- `id_pc_plus4`  out  PC_W: `id_pc + 4`.
- `id_valid`  out  1: IF/ID holds a real instruction.
- `id_rs`  out  5: `id_inst[25:21]`, to hazard detection `addr1`.
- `id_rt`  out  5: `id_inst[20:16]`, to hazard detection `addr2`.
- `stall_cnt`  out  16: stalled-cycle count (see Configuration).
- `flush_cnt`  out  16: flush count (see Configuration).

## Operation
- Registers: `pc`, `id_inst`, `id_pc`, `id_pc_plus4`, `id_valid`.
- Reset values: `pc` = RESET_PC; `id_inst`, `id_pc`, `id_pc_plus4` = 0; `id_valid` = 0; counters = 0. Hence `imem_addr` = RESET_PC, `id_rs` = `id_rt` = 0.
- Per-edge priority: redirect > stall > advance.
- Redirect (`branch_taken`=1, regardless of `stall`):
  - `pc` <= {`branch_target`[PC_W-1:2], 2'b00}.
  - `id_inst` <= 0 (NOP), `id_valid` <= 0.
  - `id_pc` and `id_pc_plus4` <= 0.
- Stall (`stall`=1, `branch_taken`=0): all registers hold their values.
- Advance (both low):
  - `pc` <= `pc` + 4, modulo 2^PC_W; 32'hFFFF_FFFC wraps to 0.
  - `id_inst` <= `imem_data`.
  - `id_pc` <= `pc`; `id_pc_plus4` <= `pc` + 4 (same wrap).
  - `id_valid` <= 1.
- `id_rs`/`id_rt` are pure wiring from `id_inst`; a flushed slot therefore reports register 0.
- Stall with `id_valid`=0: still holds; no special case.

## Timing
- `imem_addr` changes only on a clock edge or on reset assertion.
- Fetch latency 1 cycle: the word addressed in cycle N appears on `id_inst` in cycle N+1 when not stalled.
- `stall` and `branch_taken` are sampled at the rising edge. Combinational paths from `stall` into the next-state logic are allowed; no combinational path from `stall` to any output.
- Redirect penalty: the slot following the branch edge shows `id_valid`=0; the target instruction is in IF/ID one cycle later.
- `rst_n` falling mid-operation forces reset values immediately (asynchronous). Release is synchronised externally; the first edge after release advances from RESET_PC.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each edge with `stall`=1 and `branch_taken`=0.
  - `flush_cnt` increments on each edge with `branch_taken`=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: counter logic omitted; both ports tied to 0.

## Test plan
- Reset/advance: release `rst_n` with RESET_PC=0 and imem returning `addr`|32'h2000_0000. After 3 edges: `imem_addr`=12, `id_inst`=32'h2000_0008, `id_pc`=8, `id_pc_plus4`=12, `id_valid`=1.
- Stall: `id_inst`=32'h8C22_0004, `stall`=1 for 2 edges. PC and all IF/ID fields unchanged, `id_rs`=1, `id_rt`=2; with the macro, `stall_cnt`=2. Drop `stall`: advance resumes from the held PC.
- Redirect over stall: `stall`=1, `branch_taken`=1, `branch_target`=32'h0000_0103. Next cycle: `imem_addr`=32'h100, `id_valid`=0, `id_inst`=0, `id_rs`=`id_rt`=0. One cycle later `id_pc`=32'h100.
- Wrap: `pc`=32'hFFFF_FFFC, advance. Result: `imem_addr`=0, `id_pc`=32'hFFFF_FFFC, `id_pc_plus4`=0.
- Async reset mid-stream: drop `rst_n` between edges while `id_valid`=1. Outputs show reset values before the next edge: `imem_addr`=RESET_PC, `id_valid`=0.
- Counter saturation (macro on): hold `stall`=1 for 65540 edges. Result: `stall_cnt`=16'hFFFF, `flush_cnt`=0.
